// File: rtl/jr_redirect_unit.sv
// Jump-register redirect unit.
// Waits for the rs operand, latches the jump target, and steers the PC mux.
// It also flushes the two wrong-path IF/ID slots that follow the JR.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | no JR in flight; a new JR is accepted only here
//  WAIT_OPND | JR decoded, rs not yet forwarded; PC and IF/ID held
//  REDIRECT  | target latched; PC loads it at the next edge, slot 1 flushed
//  FLUSH     | second wrong-path slot flushed; held jr_valid is ignored
module jr_redirect_unit #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jr_valid,
    input  logic [ADDR_W-1:0] rs_value,
    input  logic              rs_ready,
    input  logic              ex_flush_in,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_ifid,
    output logic              stall_pc,
    output logic              busy,
    output logic              misalign,
    output logic              timeout,
    output logic [CNT_W-1:0]  jr_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        REDIRECT  = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    // The operand wait runs as a down-counter: it is loaded with MAX_WAIT-1
    // on entry to WAIT_OPND, and the wait gives up when it reaches zero.
    localparam logic [3:0] WAIT_LOAD = 4'(MAX_WAIT - 1);

    state_t     state;
    logic [3:0] wait_left;
    logic       redir_q;
    logic       flush_q;
    logic       stall_q;
    logic       busy_q;
    logic       take;

    // The operand is available for a JR that can be taken this cycle; an older flush vetoes it.
    assign take = ~ex_flush_in & rs_ready &
                  (((state == IDLE) & jr_valid) | (state == WAIT_OPND));

    // Sequencer: next state, registered Moore outputs, target latch, and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_left <= 4'd0;
            redir_q   <= 1'b0;
            flush_q   <= 1'b0;
            stall_q   <= 1'b0;
            busy_q    <= 1'b0;
            pc_target <= '0;
            misalign  <= 1'b0;
            timeout   <= 1'b0;
            jr_count  <= '0;
        end else begin
            // Default: fall back to IDLE. This is also the whole effect of ex_flush_in.
            state     <= IDLE;
            wait_left <= 4'd0;
            redir_q   <= 1'b0;
            flush_q   <= 1'b0;
            stall_q   <= 1'b0;
            busy_q    <= 1'b0;

            if (take) begin
                pc_target <= {rs_value[ADDR_W-1:2], 2'b00};
                misalign  <= misalign | (|rs_value[1:0]);
                state     <= REDIRECT;
                redir_q   <= 1'b1;
                flush_q   <= 1'b1;
                busy_q    <= 1'b1;
            end else if (!ex_flush_in) begin
                unique case (state)
                    IDLE: begin
                        if (jr_valid) begin
                            state     <= WAIT_OPND;
                            wait_left <= WAIT_LOAD;
                            stall_q   <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    WAIT_OPND: begin
                        if (wait_left == 4'd0) begin
                            timeout <= 1'b1;
                        end else begin
                            state     <= WAIT_OPND;
                            wait_left <= wait_left - 4'd1;
                            stall_q   <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    REDIRECT: begin
                        jr_count <= jr_count + CNT_W'(1);
                        state    <= FLUSH;
                        flush_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                    FLUSH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // An older flush cancels the PC load during the same cycle. The remaining outputs follow the state directly.
    always_comb begin
        pc_sel     = redir_q & ~ex_flush_in;
        flush_ifid = flush_q;
        stall_pc   = stall_q;
        busy       = busy_q;
    end

endmodule

// File: tb/tb_jr_redirect_unit.sv
// Bench for jr_redirect_unit: a per-cycle vector table checked through a scoreboard queue,
// plus hand-written sequences for counter wrap and reset in the middle of a JR.
module tb_jr_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        jr_valid;
    logic [31:0] rs_value;
    logic        rs_ready;
    logic        ex_flush_in;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        flush_ifid;
    logic        stall_pc;
    logic        busy;
    logic        misalign;
    logic        timeout;
    logic [7:0]  jr_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        jv;
        logic        rr;
        logic [31:0] rv;
        logic        xf;
        logic        ps;
        logic        fl;
        logic        st;
        logic        bz;
        logic [31:0] tgt;
        logic [7:0]  cnt;
        logic        mis;
        logic        tmo;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    jr_redirect_unit #(.ADDR_W(32), .MAX_WAIT(3), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .jr_valid   (jr_valid),
        .rs_value   (rs_value),
        .rs_ready   (rs_ready),
        .ex_flush_in(ex_flush_in),
        .pc_sel     (pc_sel),
        .pc_target  (pc_target),
        .flush_ifid (flush_ifid),
        .stall_pc   (stall_pc),
        .busy       (busy),
        .misalign   (misalign),
        .timeout    (timeout),
        .jr_count   (jr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input int jv, input int rr, input logic [31:0] rv, input int xf,
                                input int ps, input int fl, input int st, input int bz,
                                input logic [31:0] tgt, input int cnt, input int mis, input int tmo);
        vec_t v;
        v.jv = 1'(jv); v.rr = 1'(rr); v.rv = rv; v.xf = 1'(xf);
        v.ps = 1'(ps); v.fl = 1'(fl); v.st = 1'(st); v.bz = 1'(bz);
        v.tgt = tgt; v.cnt = 8'(cnt); v.mis = 1'(mis); v.tmo = 1'(tmo);
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic jv, input logic rr, input logic [31:0] rv, input logic xf);
        @(negedge clk);
        jr_valid    = jv;
        rs_ready    = rr;
        rs_value    = rv;
        ex_flush_in = xf;
    endtask

    // Drive one table row. Push its expectation, then pop it and compare while the cycle's outputs are stable.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        drive(v.jv, v.rr, v.rv, v.xf);
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk("pc_sel",     idx, 32'(pc_sel),     32'(e.ps));
        chk("flush_ifid", idx, 32'(flush_ifid), 32'(e.fl));
        chk("stall_pc",   idx, 32'(stall_pc),   32'(e.st));
        chk("busy",       idx, 32'(busy),       32'(e.bz));
        chk("pc_target",  idx, pc_target,       e.tgt);
        chk("jr_count",   idx, 32'(jr_count),   32'(e.cnt));
        chk("misalign",   idx, 32'(misalign),   32'(e.mis));
        chk("timeout",    idx, 32'(timeout),    32'(e.tmo));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc_sel"},    0, 32'(pc_sel),     32'd0);
        chk({tag, "_flush"},     0, 32'(flush_ifid), 32'd0);
        chk({tag, "_stall"},     0, 32'(stall_pc),   32'd0);
        chk({tag, "_busy"},      0, 32'(busy),       32'd0);
        chk({tag, "_target"},    0, pc_target,       32'd0);
        chk({tag, "_count"},     0, 32'(jr_count),   32'd0);
        chk({tag, "_misalign"},  0, 32'(misalign),   32'd0);
        chk({tag, "_timeout"},   0, 32'(timeout),    32'd0);
    endtask

    initial begin
        //   jv rr rs_value      xf | ps fl st bz target        cnt mis tmo
        // Direct redirect; jr_valid is held through REDIRECT/FLUSH and must not be re-taken.
        add(1, 1, 32'h0040_0120, 0,  0, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
        add(1, 1, 32'h0040_0120, 0,  1, 1, 0, 1, 32'h0040_0120, 0, 0, 0);
        add(1, 1, 32'h0040_0120, 0,  0, 1, 0, 1, 32'h0040_0120, 1, 0, 0);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h0040_0120, 1, 0, 0);
        // Operand late by two cycles.
        add(1, 0, 32'h100,       0,  0, 0, 0, 0, 32'h0040_0120, 1, 0, 0);
        add(1, 0, 32'h100,       0,  0, 0, 1, 1, 32'h0040_0120, 1, 0, 0);
        add(1, 1, 32'h100,       0,  0, 0, 1, 1, 32'h0040_0120, 1, 0, 0);
        add(0, 0, 32'h0,         0,  1, 1, 0, 1, 32'h100,       1, 0, 0);
        add(0, 0, 32'h0,         0,  0, 1, 0, 1, 32'h100,       2, 0, 0);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h100,       2, 0, 0);
        // Operand arrives on the last allowed wait cycle: the redirect is taken and no timeout is flagged.
        add(1, 0, 32'h4000,      0,  0, 0, 0, 0, 32'h100,       2, 0, 0);
        add(0, 0, 32'h0,         0,  0, 0, 1, 1, 32'h100,       2, 0, 0);
        add(0, 0, 32'h0,         0,  0, 0, 1, 1, 32'h100,       2, 0, 0);
        add(0, 1, 32'h4000,      0,  0, 0, 1, 1, 32'h100,       2, 0, 0);
        add(0, 0, 32'h0,         0,  1, 1, 0, 1, 32'h4000,      2, 0, 0);
        add(0, 0, 32'h0,         0,  0, 1, 0, 1, 32'h4000,      3, 0, 0);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h4000,      3, 0, 0);
        // Operand never arrives: three stall cycles, then timeout and no redirect.
        add(1, 0, 32'h5000,      0,  0, 0, 0, 0, 32'h4000,      3, 0, 0);
        add(0, 0, 32'h0,         0,  0, 0, 1, 1, 32'h4000,      3, 0, 0);
        add(0, 0, 32'h0,         0,  0, 0, 1, 1, 32'h4000,      3, 0, 0);
        add(0, 0, 32'h0,         0,  0, 0, 1, 1, 32'h4000,      3, 0, 0);
        add(0, 1, 32'h6000,      0,  0, 0, 0, 0, 32'h4000,      3, 0, 1);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h4000,      3, 0, 1);
        // Misaligned target, followed by an aligned one; misalign stays set.
        add(1, 1, 32'h203,       0,  0, 0, 0, 0, 32'h4000,      3, 0, 1);
        add(0, 0, 32'h0,         0,  1, 1, 0, 1, 32'h200,       3, 1, 1);
        add(0, 0, 32'h0,         0,  0, 1, 0, 1, 32'h200,       4, 1, 1);
        add(1, 1, 32'h1000,      0,  0, 0, 0, 0, 32'h200,       4, 1, 1);
        add(0, 0, 32'h0,         0,  1, 1, 0, 1, 32'h1000,      4, 1, 1);
        add(0, 0, 32'h0,         0,  0, 1, 0, 1, 32'h1000,      5, 1, 1);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h1000,      5, 1, 1);
        // Older flush during REDIRECT: pc_sel is suppressed and the count is not incremented.
        add(1, 1, 32'h2000,      0,  0, 0, 0, 0, 32'h1000,      5, 1, 1);
        add(0, 0, 32'h0,         1,  0, 1, 0, 1, 32'h2000,      5, 1, 1);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h2000,      5, 1, 1);
        // Flush together with jr_valid in IDLE: the flush wins and no target is latched.
        add(1, 1, 32'h3000,      1,  0, 0, 0, 0, 32'h2000,      5, 1, 1);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h2000,      5, 1, 1);
        // Flush while waiting for the operand.
        add(1, 0, 32'h0,         0,  0, 0, 0, 0, 32'h2000,      5, 1, 1);
        add(0, 0, 32'h0,         1,  0, 0, 1, 1, 32'h2000,      5, 1, 1);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h2000,      5, 1, 1);
        // Flush during FLUSH; jr_valid stays held.
        add(1, 1, 32'h7000,      0,  0, 0, 0, 0, 32'h2000,      5, 1, 1);
        add(1, 1, 32'h7000,      0,  1, 1, 0, 1, 32'h7000,      5, 1, 1);
        add(1, 1, 32'h7000,      1,  0, 1, 0, 1, 32'h7000,      6, 1, 1);
        add(0, 0, 32'h0,         0,  0, 0, 0, 0, 32'h7000,      6, 1, 1);

        rst_n       = 1'b0;
        jr_valid    = 1'b0;
        rs_ready    = 1'b0;
        rs_value    = 32'h0;
        ex_flush_in = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Counter wrap: 249 more redirects bring the count from 6 to 255; one more wraps it to 0.
        for (int i = 0; i < 249; i++) begin
            drive(1'b1, 1'b1, 32'h8000, 1'b0);
            drive(1'b0, 1'b0, 32'h0, 1'b0);
            drive(1'b0, 1'b0, 32'h0, 1'b0);
        end
        #2;
        chk("jr_count_255", 0, 32'(jr_count), 32'd255);
        drive(1'b1, 1'b1, 32'h8000, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("jr_count_wrap", 0, 32'(jr_count), 32'd0);
        chk("wrap_target",   0, pc_target,     32'h8000);

        // Reset asserted while waiting for the operand: every output clears before any clock edge.
        drive(1'b1, 1'b0, 32'h9000, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("pre_reset_stall", 0, 32'(stall_pc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        chk_all_zero("postreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
